vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x480 controller.
- Provides:
  - horizontal/vertical counters for pixel addressing;
  - configurable sync polarity;
  - a pixel-enable clock divider;
  - a programmable output delay that aligns sync/blank with the downstream edge-detection pixel pipeline.
- Sits between the pixel clock domain and the frame-buffer read/filter pipeline; drives the DAC sync/blank pins.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (ticks)
- HSYNC, 96, horizontal sync width (ticks)
- HBP, 48, horizontal back porch (ticks)
- VACTIVE, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hSync (0 = active-low)
- VSYNC_POL, 0, asserted level of vSync
- CLK_DIV, 1, vgaClk cycles per pixel tick (1..16)
- PIPE_DLY, 0, extra vgaClk cycles of delay on timing outputs (0..15)
- CW, 10, hCount/vCount width

Ports:
- vgaClk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-low reset
- en  in  1  run enable; low freezes divider and counters
- pixEn  out  1  high on vgaClk cycles where the counters advance (tick)
- hCount  out  CW  horizontal position, 0..HTOTAL-1
- vCount  out  CW  vertical position, 0..VTOTAL-1
- hSync  out  1  horizontal sync, delayed, polarity per HSYNC_POL
- vSync  out  1  vertical sync, delayed, polarity per VSYNC_POL
- syncB  out  1  composite sync, active-low, delayed
- blankB  out  1  low outside the active area, delayed
- active  out  1  high inside the active area, delayed
- lineStart  out  1  one-cycle pulse at the start of each line, delayed
- frameStart  out  1  one-cycle pulse at the start of each frame, delayed

Behaviour:
- Derived totals: HTOTAL = HACTIVE+HFP+HSYNC+HBP; VTOTAL = VACTIVE+VFP+VSYNC+VBP.
- Elaboration error if 2^CW < max(HTOTAL,VTOTAL), or CLK_DIV/PIPE_DLY is outside its range.
- Line order: active, FP, sync, BP. Count 0 is the first visible pixel/line.
- Divider:
  - divCnt counts 0..CLK_DIV-1 while en=1.
  - tick = en && divCnt==CLK_DIV-1; pixEn = tick.
  - With CLK_DIV=1, pixEn = en.
- Counters, on vgaClk edges where tick=1:
  - hCount increments; at HTOTAL-1 it wraps to 0.
  - On an hCount wrap, vCount increments; at VTOTAL-1 it wraps to 0.
  - No intermediate out-of-range value is ever visible.
- en=0: divCnt, hCount and vCount hold. The output pipeline keeps shifting (it reflects the held counter state).
- Raw decode (combinational from counters):
  - hs = HACTIVE+HFP <= hCount < HACTIVE+HFP+HSYNC.
  - vs = VACTIVE+VFP <= vCount < VACTIVE+VFP+VSYNC.
  - act = hCount<HACTIVE && vCount<VACTIVE.
  - ls = tick && hCount==0.
  - fs = ls && vCount==0.
- Outputs from raw decode:
  - hSync = hs ? HSYNC_POL : ~HSYNC_POL; vSync likewise with VSYNC_POL.
  - syncB = ~(hs|vs).
  - blankB = act; active = act.
  - lineStart = ls; frameStart = fs.
- Latency:
  - hCount, vCount and pixEn are direct registers/decodes (0 cycles).
  - All other outputs pass through 1+PIPE_DLY vgaClk register stages (shift register), so they lag the counter state by exactly 1+PIPE_DLY cycles.
- Reset, on a vgaClk edge with rst=0:
  - divCnt=0, hCount=0, vCount=0.
  - Every pipeline stage loads the inactive value: hSync=~HSYNC_POL, vSync=~VSYNC_POL, syncB=1, blankB=0, active=0, lineStart=0, frameStart=0.
  - These values also appear on the outputs during reset.
  - Reset mid-frame takes priority over tick.
  - After release, the first tick produces lineStart/frameStart for position (0,0).
- lineStart/frameStart pulse exactly once per line/frame for any CLK_DIV, one vgaClk cycle wide.

Test Plan:
- Reset/defaults:
  - Stimulus: rst=0 for 5 cycles, then release with en=1.
  - Required during reset: hCount=vCount=0, hSync=vSync=1, syncB=1, blankB=0.
  - Required after release: hCount steps 0..799 then 0, with vCount 0->1 on the same edge.
- Sync timing, defaults:
  - hSync=0 for exactly 96 cycles, beginning 1 cycle after hCount==656.
  - vSync=0 exactly while vCount is 490..491 (lagged 1 cycle).
  - frameStart pulses spaced 420000 cycles apart; 307200 active cycles per frame.
- CLK_DIV=2:
  - pixEn alternates 0/1.
  - Each hCount value is held 2 cycles.
  - frameStart period is 840000 cycles; lineStart is a single 1-cycle pulse per 1600 cycles.
- PIPE_DLY=3, HSYNC_POL=1:
  - hSync rises 4 cycles after hCount becomes 656 and falls 4 cycles after hCount becomes 752.
  - blankB falls 4 cycles after hCount becomes 640.
- en=0 at hCount=300 for 10 cycles:
  - hCount/vCount hold at 300 and pixEn=0.
  - hCount reads 301 one cycle after en returns to 1.
  - No lineStart pulse during the freeze.
- Reset mid-frame at hCount=700, vCount=300:
  - Next edge: hCount=vCount=0.
  - All delayed outputs are inactive for 1+PIPE_DLY cycles after release, then frameStart pulses once.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v position counters
// and a configurable-depth delay line that aligns sync/blank with the pixel pipeline.
module vga_timing_gen #(
  parameter int unsigned HACTIVE   = 640,
  parameter int unsigned HFP       = 16,
  parameter int unsigned HSYNC     = 96,
  parameter int unsigned HBP       = 48,
  parameter int unsigned VACTIVE   = 480,
  parameter int unsigned VFP       = 10,
  parameter int unsigned VSYNC     = 2,
  parameter int unsigned VBP       = 33,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned PIPE_DLY  = 0,
  parameter int unsigned CW        = 10
) (
  input  logic          vgaClk,
  input  logic          rst,
  input  logic          en,
  output logic          pixEn,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          syncB,
  output logic          blankB,
  output logic          active,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYNC + VBP;
  localparam int unsigned MAXTOT = (HTOTAL > VTOTAL) ? HTOTAL : VTOTAL;
  localparam int unsigned NSTG   = PIPE_DLY + 1;
  localparam int unsigned DW     = 4;
  localparam int unsigned XW     = CW + 1;
  localparam int unsigned OW     = 7;

  localparam logic          HPOL    = 1'(HSYNC_POL);
  localparam logic          VPOL    = 1'(VSYNC_POL);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX   = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(VTOTAL - 1);
  // Order: hSync, vSync, syncB, blankB, active, lineStart, frameStart
  localparam logic [OW-1:0] IDLE    = {~HPOL, ~VPOL, 1'b1, 4'b0000};

  if ((CW < 32) && ((1 << CW) < MAXTOT)) begin : g_cwErr
    $error("CW too narrow for HTOTAL/VTOTAL");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_divErr
    $error("CLK_DIV must be 1..16");
  end
  if (PIPE_DLY > 15) begin : g_dlyErr
    $error("PIPE_DLY must be 0..15");
  end

  logic [DW-1:0] divCnt;
  logic [DW-1:0] divNext;
  logic [CW-1:0] hNext;
  logic [CW-1:0] vNext;
  logic          tick;
  logic          hs;
  logic          vs;
  logic          act;
  logic          ls;
  logic          fs;
  logic [OW-1:0] rawVec;
  logic [OW-1:0] pipe [NSTG];

  assign tick  = en && (divCnt == DIV_MAX);
  assign pixEn = tick;

  // Next divider/counter state; wraps are resolved here so no out-of-range value is ever stored
  always_comb begin
    divNext = divCnt;
    hNext   = hCount;
    vNext   = vCount;
    if (en) begin
      divNext = tick ? '0 : divCnt + DW'(1);
    end
    if (tick) begin
      if (hCount == H_MAX) begin
        hNext = '0;
        vNext = (vCount == V_MAX) ? '0 : vCount + CW'(1);
      end else begin
        hNext = hCount + CW'(1);
      end
    end
  end

  always_ff @(posedge vgaClk) begin
    if (!rst) begin
      divCnt <= '0;
      hCount <= '0;
      vCount <= '0;
    end else begin
      divCnt <= divNext;
      hCount <= hNext;
      vCount <= vNext;
    end
  end

  // Raw decode; widened compares keep region ends that equal 2^CW from wrapping
  always_comb begin
    hs = (XW'(hCount) >= XW'(HACTIVE + HFP)) && (XW'(hCount) < XW'(HACTIVE + HFP + HSYNC));
    vs = (XW'(vCount) >= XW'(VACTIVE + VFP)) && (XW'(vCount) < XW'(VACTIVE + VFP + VSYNC));
    act = (XW'(hCount) < XW'(HACTIVE)) && (XW'(vCount) < XW'(VACTIVE));
    ls  = tick && (hCount == '0);
    fs  = ls && (vCount == '0);
    rawVec = {(hs ? HPOL : ~HPOL), (vs ? VPOL : ~VPOL), ~(hs | vs), act, act, ls, fs};
  end

  // Delay line keeps shifting while en=0 so it tracks the held counter state
  always_ff @(posedge vgaClk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NSTG); i++) pipe[i] <= IDLE;
    end else begin
      pipe[0] <= rawVec;
      for (int i = 1; i < int'(NSTG); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {hSync, vSync, syncB, blankB, active, lineStart, frameStart} = pipe[NSTG-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// tick-counting reference model, plus directed sync-width, freeze and restart checks.
module tb_vga_timing_gen;

  localparam int ND = 3;
  localparam int HA[ND] = '{640, 8, 5};
  localparam int HF[ND] = '{16, 2, 1};
  localparam int HS[ND] = '{96, 3, 2};
  localparam int HB[ND] = '{48, 2, 1};
  localparam int VA[ND] = '{480, 4, 3};
  localparam int VF[ND] = '{10, 1, 1};
  localparam int VS[ND] = '{2, 2, 1};
  localparam int VB[ND] = '{33, 1, 1};
  localparam int HP[ND] = '{0, 1, 0};
  localparam int VP[ND] = '{0, 1, 0};
  localparam int DV[ND] = '{1, 2, 3};
  localparam int PD[ND] = '{0, 3, 0};

  logic vgaClk = 1'b0;
  logic rst;
  logic en;

  logic       pixEnA, hSyncA, vSyncA, syncBA, blankBA, activeA, lineStartA, frameStartA;
  logic [9:0] hCountA, vCountA;
  logic       pixEnB, hSyncB, vSyncB, syncBB, blankBB, activeB, lineStartB, frameStartB;
  logic [3:0] hCountB, vCountB;
  logic       pixEnC, hSyncC, vSyncC, syncBC, blankBC, activeC, lineStartC, frameStartC;
  logic [3:0] hCountC, vCountC;

  always #5 vgaClk = ~vgaClk;

  vga_timing_gen dutA (
    .vgaClk(vgaClk), .rst(rst), .en(en), .pixEn(pixEnA), .hCount(hCountA), .vCount(vCountA),
    .hSync(hSyncA), .vSync(vSyncA), .syncB(syncBA), .blankB(blankBA), .active(activeA),
    .lineStart(lineStartA), .frameStart(frameStartA));

  vga_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2), .VACTIVE(4), .VFP(1), .VSYNC(2), .VBP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(2), .PIPE_DLY(3), .CW(4)
  ) dutB (
    .vgaClk(vgaClk), .rst(rst), .en(en), .pixEn(pixEnB), .hCount(hCountB), .vCount(vCountB),
    .hSync(hSyncB), .vSync(vSyncB), .syncB(syncBB), .blankB(blankBB), .active(activeB),
    .lineStart(lineStartB), .frameStart(frameStartB));

  vga_timing_gen #(
    .HACTIVE(5), .HFP(1), .HSYNC(2), .HBP(1), .VACTIVE(3), .VFP(1), .VSYNC(1), .VBP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(3), .PIPE_DLY(0), .CW(4)
  ) dutC (
    .vgaClk(vgaClk), .rst(rst), .en(en), .pixEn(pixEnC), .hCount(hCountC), .vCount(vCountC),
    .hSync(hSyncC), .vSync(vSyncC), .syncB(syncBC), .blankB(blankBC), .active(activeC),
    .lineStart(lineStartC), .frameStart(frameStartC));

  int         obsH [ND];
  int         obsV [ND];
  logic       obsPe[ND];
  logic [6:0] obsO [ND];

  always_comb begin
    obsH[0] = int'(hCountA); obsV[0] = int'(vCountA); obsPe[0] = pixEnA;
    obsH[1] = int'(hCountB); obsV[1] = int'(vCountB); obsPe[1] = pixEnB;
    obsH[2] = int'(hCountC); obsV[2] = int'(vCountC); obsPe[2] = pixEnC;
    obsO[0] = {hSyncA, vSyncA, syncBA, blankBA, activeA, lineStartA, frameStartA};
    obsO[1] = {hSyncB, vSyncB, syncBB, blankBB, activeB, lineStartB, frameStartB};
    obsO[2] = {hSyncC, vSyncC, syncBC, blankBC, activeC, lineStartC, frameStartC};
  end

  int nTests = 0;
  int nFail  = 0;

  // Reference model: position is derived from the number of ticks since reset
  int         ticks [ND];
  int         phase [ND];
  logic [6:0] dly   [ND][16];

  string outName[7] = '{"hSync", "vSync", "syncB", "blankB", "active", "lineStart", "frameStart"};

  task automatic chk(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] idleVec(input int d);
    logic hp, vp;
    hp = 1'(HP[d]);
    vp = 1'(VP[d]);
    return {~hp, ~vp, 1'b1, 4'b0000};
  endfunction

  function automatic logic [6:0] rawOf(input int d, input int h, input int v, input bit tk);
    bit hsOn, vsOn, inAct, lsOn, fsOn;
    logic hp, vp;
    hp    = 1'(HP[d]);
    vp    = 1'(VP[d]);
    hsOn  = (h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]);
    vsOn  = (v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]);
    inAct = (h < HA[d]) && (v < VA[d]);
    lsOn  = tk && (h == 0);
    fsOn  = lsOn && (v == 0);
    return {(hsOn ? hp : ~hp), (vsOn ? vp : ~vp), ~(hsOn | vsOn), inAct, inAct, lsOn, fsOn};
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < ND; d++) begin
      ticks[d] = 0;
      phase[d] = 0;
      for (int i = 0; i < 16; i++) dly[d][i] = idleVec(d);
    end
  endfunction

  // One vgaClk cycle: drive inputs at negedge, check all DUTs, then advance the model
  task automatic step(input bit r, input bit e);
    int ht, vt, h, v, nstg;
    bit tk;
    logic [6:0] expO;
    @(negedge vgaClk);
    rst = r;
    en  = e;
    #1;
    for (int d = 0; d < ND; d++) begin
      ht   = HA[d] + HF[d] + HS[d] + HB[d];
      vt   = VA[d] + VF[d] + VS[d] + VB[d];
      h    = ticks[d] % ht;
      v    = (ticks[d] / ht) % vt;
      tk   = e && (phase[d] == DV[d] - 1);
      nstg = PD[d] + 1;
      expO = dly[d][nstg-1];
      chk($sformatf("d%0d.hCount", d), obsH[d], h);
      chk($sformatf("d%0d.vCount", d), obsV[d], v);
      chk($sformatf("d%0d.pixEn", d), int'(obsPe[d]), int'(tk));
      for (int b = 0; b < 7; b++)
        chk($sformatf("d%0d.%s", d, outName[b]), int'(obsO[d][6-b]), int'(expO[6-b]));
      if (!r) begin
        ticks[d] = 0;
        phase[d] = 0;
        for (int i = 0; i < 16; i++) dly[d][i] = idleVec(d);
      end else begin
        for (int i = 15; i > 0; i--) dly[d][i] = dly[d][i-1];
        dly[d][0] = rawOf(d, h, v, tk);
        if (tk) ticks[d] = (ticks[d] + 1) % (ht * vt);
        if (e) phase[d] = (phase[d] + 1) % DV[d];
      end
    end
  endtask

  initial begin
    int   runLen, firstFsA, firstFsB, fsCntB, lsHighB, expFs, expLs, periodB;
    bit   found;
    logic prevH;
    rst = 1'b0;
    en  = 1'b1;
    modelReset();
    repeat (2) @(posedge vgaClk);

    // Reset held, then two full default lines with en=1
    repeat (5) step(1'b0, 1'b1);
    runLen = 0;
    prevH  = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      step(1'b1, 1'b1);
      if (hSyncA == 1'b0) runLen++;
      else if (prevH == 1'b0) begin
        chk("A.hSyncWidth", runLen, 96);
        runLen = 0;
      end
      prevH = hSyncA;
    end

    // Freeze at hCount=300 for 10 cycles
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      step(1'b1, 1'b1);
      if (obsH[0] == 299) found = 1'b1;
    end
    chk("A.reach299", int'(found), 1);
    repeat (10) step(1'b1, 1'b0);
    chk("A.frozen300", obsH[0], 300);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("A.resume301", obsH[0], 301);

    // Random enable with occasional reset
    for (int k = 0; k < 3000; k++)
      step(1'(($urandom_range(0, 499) != 0)), 1'(($urandom_range(0, 9) != 0)));

    // Mid-frame reset, then restart timing and pulse counts
    repeat (3) step(1'b0, 1'b1);
    firstFsA = -1;
    firstFsB = -1;
    fsCntB   = 0;
    lsHighB  = 0;
    for (int k = 0; k < 2000; k++) begin
      step(1'b1, 1'b1);
      if (frameStartA && firstFsA < 0) firstFsA = k;
      if (frameStartB && firstFsB < 0) firstFsB = k;
      if (frameStartB) fsCntB++;
      if (lineStartB) lsHighB++;
    end
    chk("A.firstFrameStart", firstFsA, (DV[0] - 1) + PD[0] + 1);
    chk("B.firstFrameStart", firstFsB, (DV[1] - 1) + PD[1] + 1);
    periodB = (HA[1] + HF[1] + HS[1] + HB[1]) * DV[1];
    expLs   = (1999 - ((DV[1] - 1) + PD[1] + 1)) / periodB + 1;
    expFs   = (1999 - ((DV[1] - 1) + PD[1] + 1)) / (periodB * (VA[1] + VF[1] + VS[1] + VB[1])) + 1;
    chk("B.frameStartCount", fsCntB, expFs);
    chk("B.lineStartHighCycles", lsHighB, expLs);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
